// File: rtl/uart_rx16.sv
`default_nettype none
// ============================================================================
// uart_rx16 : 9-bit UART receiver with even parity, OVERSAMPLE ticks per bit
// Revision  : 1.0
// ============================================================================
module uart_rx16 #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       rxclk,
  input  logic       reset_n,
  input  logic       rx_in,
  input  logic       rx_ack,
  output logic [8:0] rx_data,
  output logic       rx_valid,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam int            c_CW      = $clog2(OVERSAMPLE);
  localparam logic [c_CW-1:0] c_HALF_M1 = c_CW'(OVERSAMPLE/2 - 1);
  localparam logic [c_CW-1:0] c_FULL_M1 = c_CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 r_state, w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rxs_d;
  logic [c_CW-1:0]        r_tick;
  logic [3:0]             r_bitcnt;
  logic [8:0]             r_shift;
  logic                   r_par;
  logic [8:0]             r_data;
  logic                   r_valid, r_perr, r_ferr, r_ovr;
  logic                   w_rxs, w_bit_tick, w_load;

  assign w_rxs      = r_sync[SYNC_STAGES-1];
  assign w_bit_tick = (r_tick == c_FULL_M1);

  // Synchronizer and edge history reset to the idle (high) line level
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= '1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], rx_in};
      r_rxs_d <= w_rxs;
    end
  end

  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      S_IDLE:   if (r_rxs_d && !w_rxs) w_next = S_START;
      S_START:  if (r_tick == c_HALF_M1) w_next = w_rxs ? S_IDLE : S_DATA;
      S_DATA:   if (w_bit_tick && r_bitcnt == 4'd8) w_next = S_PARITY;
      S_PARITY: if (w_bit_tick) w_next = S_STOP;
      S_STOP: begin
        if (w_bit_tick) begin
          w_next = S_IDLE;
          w_load = 1'b1;
        end
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // START counts to the half-bit point; later states count whole bits
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick   <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:  begin
          r_tick   <= '0;
          r_bitcnt <= '0;
        end
        S_START: r_tick <= (r_tick == c_HALF_M1) ? '0 : r_tick + 1'b1;
        default: r_tick <= w_bit_tick ? '0 : r_tick + 1'b1;
      endcase
      if (r_state == S_DATA && w_bit_tick) begin
        r_shift  <= {w_rxs, r_shift[8:1]};
        r_bitcnt <= (r_bitcnt == 4'd8) ? 4'd0 : r_bitcnt + 4'd1;
      end
      if (r_state == S_PARITY && w_bit_tick) r_par <= w_rxs;
    end
  end

  // A load always wins over an ack; overrun records an unacknowledged overwrite
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= 9'h000;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_load) begin
      r_data  <= r_shift;
      r_perr  <= (^r_shift) ^ r_par;
      r_ferr  <= ~w_rxs;
      r_valid <= 1'b1;
      r_ovr   <= r_valid & ~rx_ack;
    end else if (rx_ack && r_valid) begin
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

  assign rx_data       = r_data;
  assign rx_valid      = r_valid;
  assign rx_parity_err = r_perr;
  assign rx_frame_err  = r_ferr;
  assign rx_overrun    = r_ovr;
  assign rx_busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx16.sv
`default_nettype none
// ============================================================================
// tb_uart_rx16 : directed and randomized frames against a frame-level model
// Revision     : 1.0
// ============================================================================
module tb_uart_rx16;

  localparam int OS     = 16;
  localparam int SS     = 2;
  localparam int c_T0   = SS + 1;
  localparam int c_LOAD = c_T0 + OS/2 + 11*OS;

  logic       rxclk   = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_in   = 1'b1;
  logic       rx_ack  = 1'b0;
  logic [8:0] rx_data;
  logic       rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [8:0] m_data  = 9'h000;
  logic       m_valid = 1'b0;
  logic       m_perr  = 1'b0;
  logic       m_ferr  = 1'b0;
  logic       m_ovr   = 1'b0;

  uart_rx16 #(.OVERSAMPLE(OS), .SYNC_STAGES(SS)) dut (
    .rxclk        (rxclk),
    .reset_n      (reset_n),
    .rx_in        (rx_in),
    .rx_ack       (rx_ack),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .rx_busy      (rx_busy)
  );

  always #5 rxclk = ~rxclk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".data"},  16'(rx_data),       16'(m_data));
    check({tag, ".valid"}, 16'(rx_valid),      16'(m_valid));
    check({tag, ".perr"},  16'(rx_parity_err), 16'(m_perr));
    check({tag, ".ferr"},  16'(rx_frame_err),  16'(m_ferr));
    check({tag, ".ovr"},   16'(rx_overrun),    16'(m_ovr));
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge rxclk);
    #1;
  endtask

  task automatic do_ack(input string tag);
    @(posedge rxclk); #1;
    rx_ack = 1'b1;
    @(posedge rxclk); #1;
    rx_ack = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    check_outputs(tag);
  endtask

  // One 12-bit frame; optional inter-sample glitches, ack on the load edge, or a reset abort
  task automatic send_frame(input string tag, input logic [8:0] d, input logic par,
                            input logic stop, input bit ack_at_load, input bit glitch,
                            input int abort_at);
    logic [11:0] bits;
    int rise, fall, b;
    bits = {stop, par, d, 1'b0};
    rise = -1;
    fall = -1;
    for (int c = 0; c < OS*12; c++) begin
      @(posedge rxclk); #1;
      if (rx_busy && rise < 0) rise = c;
      if (!rx_busy && rise >= 0 && fall < 0) fall = c;
      if (c == abort_at) begin
        rx_in   = 1'b1;
        reset_n = 1'b0;
        #1;
        m_data = 9'h000; m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        check_outputs({tag, ".abort"});
        check({tag, ".abort.busy"}, 16'(rx_busy), 16'd0);
        @(posedge rxclk); #1;
        reset_n = 1'b1;
        return;
      end
      if (c == c_LOAD) begin
        m_ovr   = m_valid & ~ack_at_load;
        m_valid = 1'b1;
        m_data  = d;
        m_perr  = par ^ (^d);
        m_ferr  = ~stop;
        rx_ack  = 1'b0;
        check_outputs(tag);
      end
      if (ack_at_load && c == c_LOAD - 1) rx_ack = 1'b1;
      b = c / OS;
      if (c % OS == 0) rx_in = bits[b];
      else if (glitch && b >= 1 && b <= 10 && c % OS == 3) rx_in = ~bits[b];
      else if (c % OS == 4) rx_in = bits[b];
    end
    check({tag, ".busy_rise"}, 16'(rise), 16'(c_T0));
    check({tag, ".load_edge"}, 16'(fall), 16'(c_LOAD));
  endtask

  initial begin
    int busy_cnt, busy_rise;
    logic [8:0] d;
    logic par, stop;
    bit ack_ld, glt;

    repeat (3) @(posedge rxclk);
    #1;
    check_outputs("reset");
    check("reset.busy", 16'(rx_busy), 16'd0);
    reset_n = 1'b1;
    idle(5);

    send_frame("f1A5", 9'h1A5, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    do_ack("f1A5.ack");

    do_ack("ack_idle");

    send_frame("f0F0", 9'h0F0, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    do_ack("f0F0.ack");

    // Short low glitch on an idle line: a false start only
    busy_cnt  = 0;
    busy_rise = -1;
    for (int c = 0; c < 30; c++) begin
      @(posedge rxclk); #1;
      if (rx_busy) begin
        busy_cnt++;
        if (busy_rise < 0) busy_rise = c;
      end
      if (c == 0) rx_in = 1'b0;
      if (c == 4) rx_in = 1'b1;
    end
    check("glitch.busy_rise", 16'(busy_rise), 16'(c_T0));
    check("glitch.busy_len",  16'(busy_cnt),  16'(OS/2));
    check_outputs("glitch");

    // Frame error followed by a break: no frames until a fresh falling edge
    send_frame("f155", 9'h155, ^9'h155, 1'b0, 1'b0, 1'b0, -1);
    busy_cnt = 0;
    for (int c = 0; c < 40*OS; c++) begin
      @(posedge rxclk); #1;
      if (rx_busy) busy_cnt++;
    end
    check("break.busy", 16'(busy_cnt), 16'd0);
    check_outputs("break");
    idle(OS);
    do_ack("f155.ack");

    send_frame("b2b.a", 9'h001, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    send_frame("b2b.b", 9'h1FF, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    do_ack("b2b.ack");
    send_frame("b2b.c", 9'h001, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    send_frame("b2b.d", 9'h1FF, 1'b1, 1'b1, 1'b1, 1'b0, -1);

    send_frame("abort", 9'h0AA, ^9'h0AA, 1'b1, 1'b0, 1'b0, 5*OS + 5);
    idle(5);
    check_outputs("abort.idle");
    send_frame("f0AA", 9'h0AA, ^9'h0AA, 1'b1, 1'b0, 1'b1, -1);

    for (int i = 0; i < 12; i++) begin
      d      = 9'($urandom_range(0, 511));
      par    = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
      stop   = ($urandom_range(0, 4) != 0);
      ack_ld = ($urandom_range(0, 3) == 0);
      glt    = ($urandom_range(0, 1) == 1);
      send_frame("rand", d, par, stop, ack_ld, glt, -1);
      if ($urandom_range(0, 1) == 1) do_ack("rand.ack");
      idle(stop ? $urandom_range(0, 3) : OS);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx16.md
UART_RX16 -- requirements
Module: uart_rx16

Interface
REQ-001 Parameter OVERSAMPLE, default 16, rxclk ticks per bit; SHALL be an even value >= 8.
REQ-002 Parameter SYNC_STAGES, default 2, rx_in synchronizer depth; SHALL be >= 2.
REQ-003 rxclk  input  1  sole clock; runs at OVERSAMPLE x bit rate; all flops on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 rx_in  input  1  asynchronous serial line; idles high.
REQ-006 rx_ack  input  1  consumer acknowledge of the held word.
REQ-007 rx_data  output  9  last received data word.
REQ-008 rx_valid  output  1  rx_data holds an unacknowledged word.
REQ-009 rx_parity_err  output  1  parity mismatch on the word in rx_data.
REQ-010 rx_frame_err  output  1  stop bit sampled low on the word in rx_data.
REQ-011 rx_overrun  output  1  a word was overwritten before being acknowledged.
REQ-012 rx_busy  output  1  FSM is not in IDLE.

Function
REQ-013 The frame SHALL be: start bit (0), 9 data bits LSB first, parity bit, stop bit (1); 12 bit times in total.
REQ-014 The parity bit SHALL equal the XOR of the 9 data bits (even parity); any mismatch SHALL set rx_parity_err.
REQ-015 rx_in SHALL pass through SYNC_STAGES flops; all decisions SHALL use the last stage (rxs).
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; rx_busy = (state != IDLE).
REQ-017 IDLE -> START SHALL occur only on a rxs falling edge (previous rxs 1, current rxs 0); a held-low line (break) SHALL NOT start frames.
REQ-018 On entry to START, the tick counter SHALL clear. At tick OVERSAMPLE/2-1, rxs is sampled: 0 -> DATA, 1 -> IDLE (false start, no output change).
REQ-019 In DATA, PARITY and STOP, each bit SHALL be sampled once, OVERSAMPLE ticks after the previous sample (mid-bit); the tick counter wraps at OVERSAMPLE-1.
REQ-020 DATA SHALL shift 9 samples into a shift register, LSB first, with a 4-bit bit counter 0..8; after the 9th sample -> PARITY; after 1 sample -> STOP.
REQ-021 On the STOP sample edge, the block SHALL load rx_data, rx_parity_err, rx_frame_err (stop==0), set rx_valid, and return to IDLE; the outputs are visible after that edge.
REQ-022 Latency: if t0 is the edge leaving IDLE, the start sample SHALL be at t0+OVERSAMPLE/2, and the stop sample/output load at t0+OVERSAMPLE/2+11*OVERSAMPLE (t0+184 at default).
REQ-023 When rx_ack=1 with rx_valid=1, the next edge SHALL clear rx_valid and rx_overrun; rx_data and the error flags SHALL be held until the next load.
REQ-024 rx_ack while rx_valid=0 SHALL be ignored.
REQ-025 If a load occurs while rx_valid=1 and rx_ack=0, the new word SHALL replace rx_data, rx_valid SHALL stay 1, and rx_overrun SHALL set.
REQ-026 If a load and rx_ack=1 occur on the same edge, the new word SHALL load, rx_valid SHALL stay 1, and rx_overrun SHALL clear.
REQ-027 After a frame error, the next frame SHALL require a fresh falling edge per REQ-017.
REQ-028 rx_in changes mid-frame between sample points SHALL have no effect; only mid-bit samples count.

Reset
REQ-029 When reset_n=0, the block SHALL immediately force: state IDLE, counters 0, shift register 0, synchronizer flops and edge history 1, rx_data 9'h000, and rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_busy all 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no output load; after release, reception SHALL resume at the next falling edge.

Verification
REQ-031 Frame for data 9'h1A5, parity 1, stop 1 -> rx_valid at t0+184, rx_data=9'h1A5, both error flags 0; rx_ack -> rx_valid 0 on the next edge.
REQ-032 Data 9'h0F0 with parity 1 (wrong) -> rx_data=9'h0F0, rx_parity_err=1, rx_frame_err=0.
REQ-033 Data 9'h155 with stop bit 0, then line held low for 40 bit times -> one load with rx_frame_err=1, no further frames until the line goes high and then falls.
REQ-034 Low glitch of 4 rxclk cycles on an idle line -> START then IDLE, rx_busy pulses, no rx_valid.
REQ-035 Two back-to-back frames (9'h001, 9'h1FF) with no ack -> rx_data=9'h1FF, rx_overrun=1; a second run with ack on the second load edge -> rx_overrun=0, rx_valid=1.
REQ-036 reset_n pulsed low during DATA bit 4 -> all outputs 0 immediately; a following clean frame with 9'h0AA -> received correctly.
